// File: rtl/cmp_harness_pkg.sv
// Shared definitions for the compressor test harness: unloader states,
// the default result width and the counter-width rule.
package cmp_harness_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      PAR   = 2'd2
   } unload_state_t;

   localparam int CMP_WIDTH = 33;

   function automatic int cnt_width(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

   localparam int CMP_CNT_W = cnt_width(CMP_WIDTH);

endpackage

// File: rtl/shift_unloader.sv
// Parallel-in serial-out capture of compressor results, LSB first, optional even parity.
// First bit one cycle after the accepted capture; no backpressure, dropped captures set sticky overrun.
module shift_unloader
   import cmp_harness_pkg::*;
#(
   parameter int WIDTH     = CMP_WIDTH,
   parameter int PARITY_EN = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             capture,
   input  logic [WIDTH-1:0] dst,
   output logic             dst_,
   output logic             dst_valid,
   output logic             frame_start,
   output logic             busy,
   output logic             overrun
);

   localparam int            CW   = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   unload_state_t    state;
   logic [WIDTH-1:0] sreg;
   logic [CW-1:0]    cnt;
   logic             par;

   logic last_bit;
   logic final_cyc;
   logic accept;

   // cnt is the index of the bit currently on dst_; a new frame may be
   // accepted while the final bit of the previous one is on the pin.
   always_comb begin
      last_bit  = (state == SHIFT) && (cnt == LAST);
      final_cyc = (state == PAR) || (last_bit && (PARITY_EN == 0));
      accept    = capture && ((state == IDLE) || final_cyc);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         sreg        <= '0;
         cnt         <= '0;
         par         <= 1'b0;
         dst_        <= 1'b0;
         dst_valid   <= 1'b0;
         frame_start <= 1'b0;
         busy        <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         if (capture && !accept)
            overrun <= 1'b1;

         if (accept) begin
            state       <= SHIFT;
            sreg        <= dst >> 1;
            cnt         <= '0;
            par         <= ^dst;
            dst_        <= dst[0];
            dst_valid   <= 1'b1;
            frame_start <= 1'b1;
            busy        <= 1'b1;
         end else begin
            case (state)
               SHIFT: begin
                  frame_start <= 1'b0;
                  if (last_bit) begin
                     if (PARITY_EN != 0) begin
                        state <= PAR;
                        dst_  <= par;
                     end else begin
                        state     <= IDLE;
                        dst_      <= 1'b0;
                        dst_valid <= 1'b0;
                        busy      <= 1'b0;
                     end
                  end else begin
                     dst_ <= sreg[0];
                     sreg <= sreg >> 1;
                     cnt  <= cnt + CW'(1);
                  end
               end
               default: begin
                  state       <= IDLE;
                  dst_        <= 1'b0;
                  dst_valid   <= 1'b0;
                  frame_start <= 1'b0;
                  busy        <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_shift_unloader.sv
// Bench for shift_unloader: one parity instance and one no-parity instance,
// each checked cycle by cycle against a frame-queue reference model.
module tb_shift_unloader;

   localparam int W = 33;

   typedef struct packed {
      logic d;
      logic fs;
   } item_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [1:0]   cap = 2'b00;
   logic [W-1:0] din [2];

   logic so0, vld0, fs0, bsy0, ovr0;
   logic so1, vld1, fs1, bsy1, ovr1;

   int checks = 0;
   int errors = 0;

   item_t      mq [2][$];
   logic [1:0] cur_v, cur_d, cur_fs, exp_ovr;

   always #5 clk = ~clk;

   shift_unloader #(.WIDTH(W), .PARITY_EN(1)) u_par (
      .clk(clk), .rst(rst), .capture(cap[0]), .dst(din[0]),
      .dst_(so0), .dst_valid(vld0), .frame_start(fs0), .busy(bsy0), .overrun(ovr0)
   );

   shift_unloader #(.WIDTH(W), .PARITY_EN(0)) u_nopar (
      .clk(clk), .rst(rst), .capture(cap[1]), .dst(din[1]),
      .dst_(so1), .dst_valid(vld1), .frame_start(fs1), .busy(bsy1), .overrun(ovr1)
   );

   // Reference: an accepted capture replaces the pending stream with the frame's
   // bits; acceptance is allowed when nothing is on the pin or its last item is.
   always @(posedge clk or posedge rst) begin
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            mq[k].delete();
            cur_v[k]   = 1'b0;
            cur_d[k]   = 1'b0;
            cur_fs[k]  = 1'b0;
            exp_ovr[k] = 1'b0;
         end else begin
            if (cap[k]) begin
               if (!cur_v[k] || mq[k].size() == 0) begin
                  mq[k].delete();
                  for (int i = 0; i < W; i++)
                     mq[k].push_back(item_t'({din[k][i], (i == 0) ? 1'b1 : 1'b0}));
                  if (k == 0)
                     mq[k].push_back(item_t'({^din[k], 1'b0}));
               end else begin
                  exp_ovr[k] = 1'b1;
               end
            end
            if (mq[k].size() > 0) begin
               item_t it;
               it = mq[k].pop_front();
               cur_v[k]  = 1'b1;
               cur_d[k]  = it.d;
               cur_fs[k] = it.fs;
            end else begin
               cur_v[k]  = 1'b0;
               cur_d[k]  = 1'b0;
               cur_fs[k] = 1'b0;
            end
         end
      end
   end

   function automatic logic [9:0] got_v();
      return {so0, vld0, fs0, bsy0, ovr0, so1, vld1, fs1, bsy1, ovr1};
   endfunction

   function automatic logic [9:0] want_v();
      return {cur_d[0], cur_v[0], cur_fs[0], cur_v[0], exp_ovr[0],
              cur_d[1], cur_v[1], cur_fs[1], cur_v[1], exp_ovr[1]};
   endfunction

   function automatic logic [W-1:0] rand_word();
      return {1'($urandom_range(0, 1)), 32'($urandom())};
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         cap    = 2'($urandom_range(0, 3));
         din[0] = rand_word();
         din[1] = rand_word();
         checks++;
         if (got_v() !== 10'b0) begin
            errors++;
            $display("FAIL reset_hold: outputs %b, required all zero", got_v());
         end
      end
      @(negedge clk);
      rst = 1'b0;
      cap = 2'b00;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if ({bsy0, ovr0, bsy1, ovr1} !== 4'b0) begin
            errors++;
            $display("FAIL reset_release: busy/overrun %b, required 0000", {bsy0, ovr0, bsy1, ovr1});
         end
      end
   endtask

   task automatic test_single_frame();
      logic [W-1:0] bits;
      logic         parb;
      int           fs_cnt;
      bits   = '0;
      parb   = 1'b0;
      fs_cnt = 0;
      @(negedge clk);
      din[0] = 33'h1_2345_6789;
      cap[0] = 1'b1;
      for (int j = 1; j <= 36; j++) begin
         @(negedge clk);
         if (j == 1) begin
            cap[0] = 1'b0;
            din[0] = '0;
         end
         checks++;
         if (got_v() !== want_v()) begin
            errors++;
            $display("FAIL single_cycle%0d: got %b want %b", j, got_v(), want_v());
         end
         if (j <= W) bits[j-1] = so0;
         if (j == W + 1) parb = so0;
         if (fs0) fs_cnt++;
         if (j == 1) begin
            checks++;
            if (fs0 !== 1'b1) begin
               errors++;
               $display("FAIL single_fs_first: frame_start %b, required 1", fs0);
            end
         end
         if (j == W + 2) begin
            checks++;
            if (bsy0 !== 1'b0) begin
               errors++;
               $display("FAIL single_busy_drop: busy %b, required 0", bsy0);
            end
         end
      end
      checks++;
      if (bits !== 33'h1_2345_6789) begin
         errors++;
         $display("FAIL single_stream: got %h, required 123456789", bits);
      end
      checks++;
      if (parb !== 1'b1) begin
         errors++;
         $display("FAIL single_parity: got %b, required 1", parb);
      end
      checks++;
      if (fs_cnt != 1) begin
         errors++;
         $display("FAIL single_fs_count: got %0d, required 1", fs_cnt);
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] bits;
      logic         parb;
      int           gaps;
      bits = '0;
      parb = 1'b0;
      gaps = 0;
      @(negedge clk);
      din[0] = 33'h1_2345_6789;
      cap[0] = 1'b1;
      for (int j = 1; j <= 70; j++) begin
         @(negedge clk);
         cap[0] = 1'b0;
         if (j == W + 1) begin
            cap[0] = 1'b1;
            din[0] = 33'h1_FFFF_FFFF;
         end
         checks++;
         if (got_v() !== want_v()) begin
            errors++;
            $display("FAIL b2b_cycle%0d: got %b want %b", j, got_v(), want_v());
         end
         if (j <= 2 * (W + 1) && vld0 !== 1'b1) gaps++;
         if (j > W + 1 && j <= 2 * W + 1) bits[j-W-2] = so0;
         if (j == 2 * W + 2) parb = so0;
      end
      checks++;
      if (gaps != 0) begin
         errors++;
         $display("FAIL b2b_gap: %0d idle cycles, required 0", gaps);
      end
      checks++;
      if ({bits, parb} !== {33'h1_FFFF_FFFF, 1'b1}) begin
         errors++;
         $display("FAIL b2b_second_frame: got %h/%b, required 1ffffffff/1", bits, parb);
      end
      checks++;
      if (ovr0 !== 1'b0) begin
         errors++;
         $display("FAIL b2b_overrun: got %b, required 0", ovr0);
      end
   endtask

   task automatic test_overrun();
      logic [W-1:0] d;
      logic [W-1:0] bits;
      d    = rand_word();
      bits = '0;
      @(negedge clk);
      din[0] = d;
      cap[0] = 1'b1;
      for (int j = 1; j <= 36; j++) begin
         @(negedge clk);
         cap[0] = (j == 9) ? 1'b1 : 1'b0;
         if (j == 9) din[0] = ~d;
         checks++;
         if (got_v() !== want_v()) begin
            errors++;
            $display("FAIL ovr_cycle%0d: got %b want %b", j, got_v(), want_v());
         end
         if (j <= W) bits[j-1] = so0;
         if (j == 9 || j == 10) begin
            checks++;
            if (ovr0 !== (j == 10)) begin
               errors++;
               $display("FAIL ovr_set_cycle%0d: overrun %b, required %b", j, ovr0, (j == 10));
            end
         end
      end
      checks++;
      if (bits !== d) begin
         errors++;
         $display("FAIL ovr_frame_intact: got %h, required %h", bits, d);
      end
      @(negedge clk);
      din[0] = rand_word();
      cap[0] = 1'b1;
      for (int j = 1; j <= 36; j++) begin
         @(negedge clk);
         cap[0] = 1'b0;
         checks++;
         if (got_v() !== want_v()) begin
            errors++;
            $display("FAIL ovr_next_cycle%0d: got %b want %b", j, got_v(), want_v());
         end
      end
      checks++;
      if (ovr0 !== 1'b1) begin
         errors++;
         $display("FAIL ovr_sticky: overrun %b, required 1", ovr0);
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [W-1:0] d2;
      logic [W-1:0] bits;
      logic         parb;
      bits = '0;
      parb = 1'b0;
      @(negedge clk);
      din[0] = rand_word();
      cap[0] = 1'b1;
      for (int j = 1; j <= 14; j++) begin
         @(negedge clk);
         cap[0] = 1'b0;
      end
      rst = 1'b1;
      #1;
      checks++;
      if (got_v() !== 10'b0) begin
         errors++;
         $display("FAIL rst_mid_immediate: outputs %b, required all zero", got_v());
      end
      @(negedge clk);
      rst = 1'b0;
      d2  = rand_word();
      @(negedge clk);
      din[0] = d2;
      cap[0] = 1'b1;
      for (int j = 1; j <= 36; j++) begin
         @(negedge clk);
         cap[0] = 1'b0;
         checks++;
         if (got_v() !== want_v()) begin
            errors++;
            $display("FAIL rst_fresh_cycle%0d: got %b want %b", j, got_v(), want_v());
         end
         if (j <= W) bits[j-1] = so0;
         if (j == W + 1) parb = so0;
      end
      checks++;
      if ({bits, parb} !== {d2, ^d2}) begin
         errors++;
         $display("FAIL rst_fresh_frame: got %h/%b, required %h/%b", bits, parb, d2, ^d2);
      end
   endtask

   task automatic test_no_parity();
      int vcnt;
      int ones;
      vcnt = 0;
      ones = 0;
      @(negedge clk);
      din[1] = '0;
      cap[1] = 1'b1;
      for (int j = 1; j <= 40; j++) begin
         @(negedge clk);
         cap[1] = 1'b0;
         checks++;
         if (got_v() !== want_v()) begin
            errors++;
            $display("FAIL nopar_cycle%0d: got %b want %b", j, got_v(), want_v());
         end
         if (vld1) vcnt++;
         if (so1) ones++;
      end
      checks++;
      if (vcnt != W || ones != 0) begin
         errors++;
         $display("FAIL nopar_length: valid %0d ones %0d, required 33 and 0", vcnt, ones);
      end
   endtask

   task automatic test_random();
      for (int j = 0; j < 600; j++) begin
         @(negedge clk);
         checks++;
         if (got_v() !== want_v()) begin
            errors++;
            $display("FAIL random_cycle%0d: got %b want %b", j, got_v(), want_v());
         end
         cap[0] = ($urandom_range(0, 11) == 0);
         cap[1] = ($urandom_range(0, 11) == 0);
         din[0] = rand_word();
         din[1] = rand_word();
      end
      cap = 2'b00;
      for (int j = 0; j < 40; j++) begin
         @(negedge clk);
         checks++;
         if (got_v() !== want_v()) begin
            errors++;
            $display("FAIL random_drain%0d: got %b want %b", j, got_v(), want_v());
         end
      end
   endtask

   initial begin
      din[0] = '0;
      din[1] = '0;
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_overrun();
      test_reset_mid_frame();
      test_no_parity();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
